vdff_delay_sched: RTL and testbench



---
 rtl/vdff_delay_sched_if.sv | 26 ++
 rtl/vdff_delay_sched.sv | 150 +++++++++++++++
 tb/tb_vdff_delay_sched.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdff_delay_sched_if.sv
// Request/commit bus of vdff_delay_sched: requester handshake plus committed output.
// master = requester/consumer side, slave = scheduler.
interface vdff_delay_sched_if #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned SIZE = 10
) ();
   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]      req_valid;
   logic [NREQ*SIZE-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic [SIZE-1:0]      out_data;
   logic                 out_valid;
   logic [IDX_W-1:0]     out_src;
   logic                 busy;

   modport master (
      output req_valid, req_data,
      input  req_ready, out_data, out_valid, out_src, busy
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, out_data, out_valid, out_src, busy
   );
endinterface

// File: rtl/vdff_delay_sched.sv
// Shares one delayed output register among NREQ requesters, each with a programmable delay.
// Optional macro VDFF_SCHED_FIXED_PRI_EN: fixed lowest-index priority instead of round-robin.
module vdff_delay_sched #(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned SIZE      = 10,
   parameter int unsigned DLY_W     = 5,
   parameter int unsigned DEF_DELAY = 1,
   localparam int unsigned IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [DLY_W-1:0]  cfg_delay,
   vdff_delay_sched_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e             state_q, state_d;
   logic [DLY_W-1:0]   cnt_q, cnt_d;
   logic [SIZE-1:0]    data_q, data_d;
   logic [IDX_W-1:0]   src_q, src_d;
   logic [SIZE-1:0]    out_data_q, out_data_d;
   logic [IDX_W-1:0]   out_src_q, out_src_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic [DLY_W-1:0]   dly_q [NREQ];
   logic [DLY_W-1:0]   dly_d [NREQ];
`ifndef VDFF_SCHED_FIXED_PRI_EN
   logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

   logic [NREQ-1:0]    grant;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   cand_idx;
   logic               found;
   int unsigned        cand;
   logic [DLY_W-1:0]   sel_dly;
   logic [DLY_W-1:0]   eff_dly;

   // Scan requesters starting from the priority origin; first valid one wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand_idx  = '0;
      found     = 1'b0;
      cand      = 0;
      if (state_q == StIdle) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef VDFF_SCHED_FIXED_PRI_EN
            cand = k;
`else
            cand = 32'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
`endif
            cand_idx = IDX_W'(cand);
            if (!found && bus.req_valid[cand_idx]) begin
               found     = 1'b1;
               grant_idx = cand_idx;
            end
         end
         if (found) grant[grant_idx] = 1'b1;
      end
   end

   // A stored delay of zero still costs one cycle so the counter never underflows.
   assign sel_dly = dly_q[grant_idx];
   assign eff_dly = (sel_dly == '0) ? DLY_W'(1) : sel_dly;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      src_d       = src_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = 1'b0;
      busy_d      = busy_q;
      dly_d       = dly_q;
`ifndef VDFF_SCHED_FIXED_PRI_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StWait;
               cnt_d   = eff_dly;
               data_d  = bus.req_data[32'(grant_idx)*SIZE +: SIZE];
               src_d   = grant_idx;
               busy_d  = 1'b1;
`ifndef VDFF_SCHED_FIXED_PRI_EN
               ptr_d   = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDX_W'(1);
`endif
            end
         end
         StWait: begin
            if (cnt_q == DLY_W'(1)) begin
               state_d     = StIdle;
               out_data_d  = data_q;
               out_src_d   = src_q;
               out_valid_d = 1'b1;
               busy_d      = 1'b0;
            end else begin
               cnt_d = cnt_q - DLY_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      // Counter was loaded from dly_q above, so a same-edge write only affects later accepts.
      if (cfg_we && (32'(cfg_idx) < NREQ)) dly_d[cfg_idx] = cfg_delay;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         data_q      <= '0;
         src_q       <= '0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < NREQ; i++) dly_q[i] <= DLY_W'(DEF_DELAY);
`ifndef VDFF_SCHED_FIXED_PRI_EN
         ptr_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         src_q       <= src_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         dly_q       <= dly_d;
`ifndef VDFF_SCHED_FIXED_PRI_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign bus.req_ready = grant;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_src   = out_src_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_vdff_delay_sched.sv
// Directed bench for vdff_delay_sched; NREQ=3 so an out-of-range cfg_idx (3) is expressible.
// Requester 2 is never driven, so two active requesters still alternate 0,1,0,1.
module tb_vdff_delay_sched;
   localparam int unsigned NREQ      = 3;
   localparam int unsigned SIZE      = 10;
   localparam int unsigned DLY_W     = 5;
   localparam int unsigned DEF_DELAY = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_idx = '0;
   logic [4:0] cfg_delay = '0;
   int         total = 0;
   int         bad = 0;

   vdff_delay_sched_if #(.NREQ(NREQ), .SIZE(SIZE)) bus_if ();

   vdff_delay_sched #(
      .NREQ(NREQ), .SIZE(SIZE), .DLY_W(DLY_W), .DEF_DELAY(DEF_DELAY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_delay(cfg_delay), .bus(bus_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [4:0] val);
      cfg_we = 1'b1; cfg_idx = idx; cfg_delay = val;
      tick();
      cfg_we = 1'b0;
   endtask

   // One request from idx; n = edges from accept to the commit (99 if none).
   // cfg_at: -1 no write, 0 write on the accept edge, 1 write on the first WAIT edge.
   task automatic run_txn(input int idx, input logic [9:0] data, input int cfg_at,
                          input logic [1:0] widx, input logic [4:0] wval, output int n);
      bus_if.req_data = '0;
      bus_if.req_data[idx*SIZE +: SIZE] = data;
      bus_if.req_valid = '0;
      bus_if.req_valid[idx] = 1'b1;
      if (cfg_at == 0) begin cfg_we = 1'b1; cfg_idx = widx; cfg_delay = wval; end
      tick();
      bus_if.req_valid = '0;
      cfg_we = 1'b0;
      if (cfg_at == 1) begin cfg_we = 1'b1; cfg_idx = widx; cfg_delay = wval; end
      n = 99;
      for (int c = 1; c <= 40; c++) begin
         tick();
         cfg_we = 1'b0;
         if (bus_if.out_valid) begin n = c; break; end
      end
   endtask

   task automatic test_reset();
      bus_if.req_valid = '0;
      bus_if.req_data  = '0;
      rst_n = 1'b0;
      repeat (2) tick();
      total++; if (bus_if.out_data !== 10'h000) begin bad++;
         $display("FAIL reset_out_data: got %h want 000", bus_if.out_data); end
      total++; if (bus_if.out_valid !== 1'b0) begin bad++;
         $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
      total++; if (bus_if.out_src !== 2'd0) begin bad++;
         $display("FAIL reset_out_src: got %0d want 0", bus_if.out_src); end
      total++; if (bus_if.busy !== 1'b0) begin bad++;
         $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bus_if.req_data[0 +: SIZE] = 10'h155;
      bus_if.req_valid = 3'b001;
      #1;
      total++; if (bus_if.req_ready !== 3'b001) begin bad++;
         $display("FAIL basic_ready: got %b want 001", bus_if.req_ready); end
      tick();
      bus_if.req_valid = '0;
      total++; if (bus_if.busy !== 1'b1) begin bad++;
         $display("FAIL basic_busy_wait: got %b want 1", bus_if.busy); end
      total++; if (bus_if.out_valid !== 1'b0) begin bad++;
         $display("FAIL basic_early_valid: got %b want 0", bus_if.out_valid); end
      tick();
      total++; if (bus_if.out_valid !== 1'b1) begin bad++;
         $display("FAIL basic_valid: got %b want 1", bus_if.out_valid); end
      total++; if (bus_if.out_data !== 10'h155) begin bad++;
         $display("FAIL basic_data: got %h want 155", bus_if.out_data); end
      total++; if (bus_if.out_src !== 2'd0) begin bad++;
         $display("FAIL basic_src: got %0d want 0", bus_if.out_src); end
      total++; if (bus_if.busy !== 1'b0) begin bad++;
         $display("FAIL basic_busy_done: got %b want 0", bus_if.busy); end
      tick();
      total++; if (bus_if.out_valid !== 1'b0) begin bad++;
         $display("FAIL basic_valid_pulse: got %b want 0", bus_if.out_valid); end
      total++; if (bus_if.out_data !== 10'h155) begin bad++;
         $display("FAIL basic_data_hold: got %h want 155", bus_if.out_data); end
   endtask

   task automatic test_long_delay();
      int n;
      int ready_err;
      n = 99;
      ready_err = 0;
      cfg_write(2'd1, 5'd20);
      bus_if.req_data[1*SIZE +: SIZE] = 10'h3FF;
      bus_if.req_valid = 3'b010;
      tick();
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (bus_if.out_valid) begin n = c; break; end
         if (bus_if.req_ready !== 3'b000) ready_err++;
      end
      bus_if.req_valid = '0;
      total++; if (n != 20) begin bad++;
         $display("FAIL long_latency: got %0d want 20", n); end
      total++; if (bus_if.out_data !== 10'h3FF) begin bad++;
         $display("FAIL long_data: got %h want 3ff", bus_if.out_data); end
      total++; if (bus_if.out_src !== 2'd1) begin bad++;
         $display("FAIL long_src: got %0d want 1", bus_if.out_src); end
      total++; if (ready_err != 0) begin bad++;
         $display("FAIL long_ready_in_wait: got %0d nonzero cycles want 0", ready_err); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] grants [4];
      logic [1:0] srcs [4];
      logic [9:0] datas [4];
      logic [2:0] exp_g [4];
      logic [1:0] exp_s [4];
      int ng;
      int nc;
`ifdef VDFF_SCHED_FIXED_PRI_EN
      exp_g = '{3'b001, 3'b001, 3'b001, 3'b001};
      exp_s = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
      exp_g = '{3'b001, 3'b010, 3'b001, 3'b010};
      exp_s = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
      for (int i = 0; i < 4; i++) begin grants[i] = 'x; srcs[i] = 'x; datas[i] = 'x; end
      cfg_write(2'd0, 5'd1);
      cfg_write(2'd1, 5'd2);
      bus_if.req_data[0 +: SIZE]    = 10'h0A0;
      bus_if.req_data[SIZE +: SIZE] = 10'h0B1;
      bus_if.req_valid = 3'b011;
      #1;
      grants[0] = bus_if.req_ready;
      ng = 1;
      nc = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (bus_if.out_valid) begin
            srcs[nc] = bus_if.out_src;
            datas[nc] = bus_if.out_data;
            nc++;
            if (nc == 4) begin bus_if.req_valid = '0; break; end
         end
         if (bus_if.req_ready !== 3'b000 && ng < 4) begin grants[ng] = bus_if.req_ready; ng++; end
      end
      bus_if.req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         total++; if (grants[i] !== exp_g[i]) begin bad++;
            $display("FAIL rr_grant%0d: got %b want %b", i, grants[i], exp_g[i]); end
         total++; if (srcs[i] !== exp_s[i]) begin bad++;
            $display("FAIL rr_src%0d: got %0d want %0d", i, srcs[i], exp_s[i]); end
         total++; if (datas[i] !== ((exp_s[i] == 2'd0) ? 10'h0A0 : 10'h0B1)) begin bad++;
            $display("FAIL rr_data%0d: got %h want %h", i, datas[i],
                     (exp_s[i] == 2'd0) ? 10'h0A0 : 10'h0B1); end
      end
   endtask

   task automatic test_zero_and_midwait();
      int n;
      cfg_write(2'd0, 5'd0);
      run_txn(0, 10'h0AA, -1, 2'd0, 5'd0, n);
      total++; if (n != 1) begin bad++;
         $display("FAIL zero_delay_latency: got %0d want 1", n); end
      total++; if (bus_if.out_data !== 10'h0AA) begin bad++;
         $display("FAIL zero_delay_data: got %h want 0aa", bus_if.out_data); end
      cfg_write(2'd1, 5'd4);
      run_txn(1, 10'h111, 1, 2'd1, 5'd7, n);
      total++; if (n != 4) begin bad++;
         $display("FAIL midwait_write_latency: got %0d want 4", n); end
      run_txn(1, 10'h222, 0, 2'd1, 5'd3, n);
      total++; if (n != 7) begin bad++;
         $display("FAIL sameedge_write_latency: got %0d want 7", n); end
      total++; if (bus_if.out_data !== 10'h222) begin bad++;
         $display("FAIL sameedge_data: got %h want 222", bus_if.out_data); end
      run_txn(1, 10'h333, -1, 2'd0, 5'd0, n);
      total++; if (n != 3) begin bad++;
         $display("FAIL after_sameedge_latency: got %0d want 3", n); end
   endtask

   task automatic test_reset_mid_wait();
      int n;
      int pulses;
      pulses = 0;
      cfg_write(2'd1, 5'd10);
      bus_if.req_data[SIZE +: SIZE] = 10'h0CC;
      bus_if.req_valid = 3'b010;
      tick();
      bus_if.req_valid = '0;
      repeat (2) tick();
      rst_n = 1'b0;
      #2;
      total++; if (bus_if.out_data !== 10'h000) begin bad++;
         $display("FAIL rstwait_data: got %h want 000", bus_if.out_data); end
      total++; if (bus_if.busy !== 1'b0) begin bad++;
         $display("FAIL rstwait_busy: got %b want 0", bus_if.busy); end
      total++; if (bus_if.out_src !== 2'd0) begin bad++;
         $display("FAIL rstwait_src: got %0d want 0", bus_if.out_src); end
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus_if.out_valid !== 1'b0) pulses++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus_if.out_valid !== 1'b0) pulses++;
      end
      total++; if (pulses != 0) begin bad++;
         $display("FAIL rstwait_no_commit: got %0d pulses want 0", pulses); end
      run_txn(1, 10'h0DD, -1, 2'd0, 5'd0, n);
      total++; if (n != 1) begin bad++;
         $display("FAIL rstwait_def_delay: got %0d want 1", n); end
   endtask

   task automatic test_cfg_idx_range();
      int n;
      cfg_write(2'd1, 5'd5);
      cfg_write(2'd3, 5'd9);
      run_txn(1, 10'h1E1, -1, 2'd0, 5'd0, n);
      total++; if (n != 5) begin bad++;
         $display("FAIL cfgidx_req1_latency: got %0d want 5", n); end
      total++; if (bus_if.out_data !== 10'h1E1) begin bad++;
         $display("FAIL cfgidx_req1_data: got %h want 1e1", bus_if.out_data); end
      run_txn(0, 10'h2E2, -1, 2'd0, 5'd0, n);
      total++; if (n != 1) begin bad++;
         $display("FAIL cfgidx_req0_latency: got %0d want 1", n); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_long_delay();
      test_back_to_back();
      test_zero_and_midwait();
      test_reset_mid_wait();
      test_cfg_idx_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
